// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared constants and types for the MIPS inter-stage pipeline registers.
//   - Default reset and exception-handler PCs.
//   - ExcCode width and the ExcCode values the pipeline raises.
//   - The per-edge action a stage register takes, plus a priority decoder
//     that turns the hazard-unit controls into that action.
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

   localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
   localparam logic [31:0] HANDLER_ADDR  = 32'h0000_4180;

   localparam int EXC_CODE_W = 5;

   localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'd8;
   localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

   // What the register does on a (non-reset) rising edge.
   typedef enum logic [2:0] {
      ACT_LOAD       = 3'd0,  // capture upstream slot
      ACT_HOLD       = 3'd1,  // stall: keep everything
      ACT_FLUSH      = 3'd2,  // bubble, take upstream PC/BD
      ACT_FLUSH_HOLD = 3'd3,  // bubble, keep own PC/BD
      ACT_REDIRECT   = 3'd4   // bubble at the handler PC
   } stage_act_e;

   // Redirect beats flush, flush beats stall, stall beats load.
   function automatic stage_act_e decode_action(input logic req,
                                                input logic flush,
                                                input logic stall);
      stage_act_e act;
      if (req)                 act = ACT_REDIRECT;
      else if (flush && stall) act = ACT_FLUSH_HOLD;
      else if (flush)          act = ACT_FLUSH;
      else if (stall)          act = ACT_HOLD;
      else                     act = ACT_LOAD;
      return act;
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter used for pipeline statistics. Sticks at all-ones,
// never wraps; cleared only by reset.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous, active-high clear
//   inc    in  1      count this edge
//   cnt    out WIDTH  current count
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register (F/D, D/E, E/M, M/W). Carries PC, instruction,
// valid, branch-delay flag, ExcCode and a generic payload. The hazard unit
// drives stall/flush; req redirects to the exception handler.
// Edge priority: reset > req > flush > stall > load. All outputs registered.
//
// Optional feature macro: PIPE_STATS_EN
//   defined   -> stat_stall / stat_bubble saturating counters and STAT_W exist
//   undefined -> those ports, counters and STAT_W are absent
//
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   stall, flush, req  hold / bubble keeping PC / bubble at HANDLER_PC
//   in_valid, in_pc, in_instr, in_bd, in_exc, in_exc_local, in_data
//                      upstream slot (in_exc_local = this stage's exception)
//   out_valid, out_pc, out_instr, out_bd, out_exc, out_data
//                      registered slot to the downstream stage
//   stat_stall         stalled edges (stall & !req)        [PIPE_STATS_EN]
//   stat_bubble        bubbles loaded (flush | req)         [PIPE_STATS_EN]
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int          DATA_W     = 32,
   parameter int          EXC_W      = EXC_CODE_W,
   parameter logic [31:0] PC_RESET   = PC_RESET_ADDR,
   parameter logic [31:0] HANDLER_PC = HANDLER_ADDR
`ifdef PIPE_STATS_EN
   ,
   parameter int          STAT_W     = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              req,
   input  logic              in_valid,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_instr,
   input  logic              in_bd,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [EXC_W-1:0]  in_exc_local,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic              out_bd,
   output logic [EXC_W-1:0]  out_exc,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_stall,
   output logic [STAT_W-1:0] stat_bubble
`endif
);

   logic              valid_q, valid_d;
   logic [31:0]       pc_q,    pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              bd_q,    bd_d;
   logic [EXC_W-1:0]  exc_q,   exc_d;
   logic [DATA_W-1:0] data_q,  data_d;

   stage_act_e       act;
   logic [EXC_W-1:0] exc_merged;

   assign act = decode_action(req, flush, stall);

   // Earlier stage's exception wins; a non-valid slot never carries one.
   assign exc_merged = !in_valid            ? '0 :
                       (in_exc != '0)       ? in_exc : in_exc_local;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can infer a latch.
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      bd_d    = bd_q;
      exc_d   = exc_q;
      data_d  = data_q;
      unique case (act)
         ACT_REDIRECT: begin
            valid_d = 1'b0;
            pc_d    = HANDLER_PC;
            instr_d = '0;
            bd_d    = 1'b0;
            exc_d   = '0;
            data_d  = '0;
         end
         // Flushed slot keeps a PC/BD so the EPC of a later exception is right.
         ACT_FLUSH: begin
            valid_d = 1'b0;
            pc_d    = in_pc;
            instr_d = '0;
            bd_d    = in_bd;
            exc_d   = '0;
            data_d  = '0;
         end
         ACT_FLUSH_HOLD: begin
            valid_d = 1'b0;
            instr_d = '0;
            exc_d   = '0;
            data_d  = '0;
         end
         ACT_HOLD: ;
         ACT_LOAD: begin
            valid_d = in_valid;
            pc_d    = in_pc;
            instr_d = in_instr;
            bd_d    = in_bd;
            exc_d   = exc_merged;
            data_d  = in_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the payload is reset too; downstream decodes instr=0 as a nop
      // without looking at valid, so no field may come up X.
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         bd_q    <= 1'b0;
         exc_q   <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         bd_q    <= bd_d;
         exc_q   <= exc_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_pc    = pc_q;
   assign out_instr = instr_q;
   assign out_bd    = bd_q;
   assign out_exc   = exc_q;
   assign out_data  = data_q;

`ifdef PIPE_STATS_EN
   // A redirect cancels the stall, so that edge is counted as a bubble only.
   pipe_sat_counter #(.WIDTH(STAT_W)) u_stat_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (stall & ~req),
      .cnt   (stat_stall)
   );

   pipe_sat_counter #(.WIDTH(STAT_W)) u_stat_bubble (
      .clk   (clk),
      .reset (reset),
      .inc   (flush | req),
      .cnt   (stat_bubble)
   );
`endif

endmodule
